// File: rtl/imm_encoder.sv
// Iterative ARM data-processing immediate encoder: finds the smallest rotate such that
// valueIn == ROR(imm8, 2*rotate). Optional inverted (MVN/BIC) second pass under IMM_ENCODER_INVERT_EN.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueIn,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [11:0] data12Out,
    output logic        invertOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] work_r, work_s;
    logic [3:0]  rot_r, rot_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        found_r, found_s;
    logic [11:0] data_r, data_s;
    logic [31:0] cand_s;
    logic        accept_s;
`ifdef IMM_ENCODER_INVERT_EN
    logic        pass_r, pass_s;
    logic        inv_r, inv_s;
`endif

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    // Next-state and next-output logic for the rotation search
    always_comb begin
        state_s  = state_r;
        work_s   = work_r;
        rot_s    = rot_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        found_s  = found_r;
        data_s   = data_r;
`ifdef IMM_ENCODER_INVERT_EN
        pass_s   = pass_r;
        inv_s    = inv_r;
`endif
        cand_s   = rol32(work_r, {rot_r, 1'b0});
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));

        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    work_s  = valueIn;
                    rot_s   = 4'd0;
                    found_s = 1'b0;
                    data_s  = 12'd0;
`ifdef IMM_ENCODER_INVERT_EN
                    pass_s  = 1'b0;
                    inv_s   = 1'b0;
`endif
                    busy_s  = 1'b1;
                    state_s = SEARCH;
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH: begin
                busy_s = 1'b1;
                if (cand_s[31:8] == 24'd0) begin
                    data_s  = {rot_r, cand_s[7:0]};
                    found_s = 1'b1;
`ifdef IMM_ENCODER_INVERT_EN
                    inv_s   = pass_r;
`endif
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = DONE;
                end else if (rot_r == 4'd15) begin
`ifdef IMM_ENCODER_INVERT_EN
                    // Direct miss: retry the search on the complemented constant
                    if (!pass_r) begin
                        work_s = ~work_r;
                        rot_s  = 4'd0;
                        pass_s = 1'b1;
                    end else begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = DONE;
                    end
`else
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = DONE;
`endif
                end else begin
                    rot_s = rot_r + 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            work_r  <= 32'd0;
            rot_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            found_r <= 1'b0;
            data_r  <= 12'd0;
`ifdef IMM_ENCODER_INVERT_EN
            pass_r  <= 1'b0;
            inv_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            rot_r   <= rot_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            found_r <= found_s;
            data_r  <= data_s;
`ifdef IMM_ENCODER_INVERT_EN
            pass_r  <= pass_s;
            inv_r   <= inv_s;
`endif
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign found     = found_r;
    assign data12Out = data_r;
`ifdef IMM_ENCODER_INVERT_EN
    assign invertOut = inv_r;
`else
    assign invertOut = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed table, corner sequences, and random
// vectors checked against a definition-based search model.
module tb_imm_encoder;

`ifdef IMM_ENCODER_INVERT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] valueIn = 32'd0;
    logic        busy, done, found, invertOut;
    logic [11:0] data12Out;

    int n_cmp = 0;
    int n_mis = 0;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .valueIn   (valueIn),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .data12Out (data12Out),
        .invertOut (invertOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic        f;
        logic [11:0] d;
        logic        inv;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference: smallest rotate r (and imm8) such that ROR(imm8, 2r) equals the value
    function automatic void ref_encode(input logic [31:0] v, output logic f, output logic [11:0] d,
                                       output logic inv, output int lat);
        f = 1'b0; d = 12'd0; inv = 1'b0; lat = INV_EN ? 32 : 16;
        for (int p = 0; p < (INV_EN ? 2 : 1); p++) begin
            logic [31:0] t;
            t = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                for (int i = 0; i < 256; i++) begin
                    if (!f && (ror32(32'(i), 2 * r) == t)) begin
                        f   = 1'b1;
                        d   = {r[3:0], i[7:0]};
                        inv = (p == 1);
                        lat = 16 * p + r + 1;
                    end
                end
            end
        end
    endfunction

    task automatic launch_now(input logic [31:0] v);
        valueIn = v;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic launch(input logic [31:0] v);
        @(negedge clk);
        launch_now(v);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic check_result(input string tag, input vec_t e, input int lat);
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_found"}, {31'd0, found}, {31'd0, e.f});
        chk({tag, "_data"}, {20'd0, data12Out}, {20'd0, e.d});
        chk({tag, "_inv"}, {31'd0, invertOut}, {31'd0, e.inv});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        vec_t e;
        int   lat;
        int   seen;

        tbl[0] = '{32'h000000FF, 1'b1, 12'h0FF, 1'b0, 1};
        tbl[1] = '{32'hFF000000, 1'b1, 12'h4FF, 1'b0, 5};
        tbl[2] = '{32'h000003FC, 1'b1, 12'hFFF, 1'b0, 16};
        tbl[3] = '{32'h00000102, 1'b0, 12'h000, 1'b0, INV_EN ? 32 : 16};
        tbl[4] = '{32'hFFFFFF00, INV_EN, INV_EN ? 12'h0FF : 12'h000, INV_EN, INV_EN ? 17 : 16};
        tbl[5] = '{32'h00000000, 1'b1, 12'h000, 1'b0, 1};
        tbl[6] = '{32'h80000001, 1'b1, 12'h106, 1'b0, 2};
        tbl[7] = '{32'hFFFFFFFF, INV_EN, 12'h000, INV_EN, INV_EN ? 17 : 16};

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_found", {31'd0, found}, 32'd0);
        chk("rst_data", {20'd0, data12Out}, 32'd0);
        chk("rst_inv", {31'd0, invertOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            launch(tbl[k].v);
            wait_done(lat);
            check_result($sformatf("tbl%0d", k), tbl[k], lat);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_done_pulse", k), {31'd0, done}, 32'd0);
            chk($sformatf("tbl%0d_data_held", k), {20'd0, data12Out}, {20'd0, tbl[k].d});
        end

        // Second start mid-search is ignored; start in the DONE cycle is accepted
        launch(32'h00000102);
        @(posedge clk); #1;
        @(posedge clk); #1;
        valueIn = 32'h000000FF;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        e = '{32'h00000102, 1'b0, 12'h000, 1'b0, INV_EN ? 32 : 16};
        check_result("ignored_start", e, lat + 3);
        launch_now(32'hFF000000);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        chk("b2b_found_cleared", {31'd0, found}, 32'd0);
        wait_done(lat);
        e = '{32'hFF000000, 1'b1, 12'h4FF, 1'b0, 5};
        check_result("b2b", e, lat);

        // Reset mid-search aborts with no done pulse
        launch(32'h00000102);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_found", {31'd0, found}, 32'd0);
        chk("arst_data", {20'd0, data12Out}, 32'd0);
        chk("arst_inv", {31'd0, invertOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("arst_no_done", 32'(seen), 32'd0);
        launch(32'h000000FF);
        wait_done(lat);
        e = '{32'h000000FF, 1'b1, 12'h0FF, 1'b0, 1};
        check_result("post_rst", e, lat);

        // Random vectors against the reference model
        for (int k = 0; k < 150; k++) begin
            logic [31:0] v, enc;
            int mode;
            mode = $urandom_range(0, 3);
            enc  = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
            case (mode)
                0: v = $urandom;
                1: v = enc;
                2: v = ~enc;
                default: v = 32'($urandom_range(0, 1023));
            endcase
            e.v = v;
            ref_encode(v, e.f, e.d, e.inv, e.lat);
            launch(v);
            wait_done(lat);
            check_result($sformatf("rnd%0d_%08h", k, v), e, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Iterative encoder that converts a 32-bit constant into the ARM data-processing immediate field. The field is `{rotate[3:0], imm8[7:0]}`, and the constant equals `imm8` rotated right by `2*rotate`. It is the inverse of operand-2 immediate decoding. It sits beside the decode/operand path and serves the assembler-check and constant-load logic, which must know whether a value is directly encodable. The search tests one rotation per clock under a start/busy/done handshake.

## Interface
Parameters: none.

Clock and reset are one clock, with reset asynchronous and active-high.
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- valueIn  input  32  constant to encode; captured on accepted start
- busy  output  1  high while searching
- done  output  1  single-cycle pulse when result valid
- found  output  1  1 = encoding exists; valid from done, held until next accepted start
- data12Out  output  12  `{rotate, imm8}`; 0 when found=0
- invertOut  output  1  1 = encoding is of ~valueIn (MVN/BIC form); tied 0 unless macro set

## Operation
- FSM states:
  - IDLE --start--> SEARCH.
  - SEARCH --hit or last rotation tested--> DONE.
  - DONE --start--> SEARCH.
  - DONE --no start--> IDLE.
- On accepted start:
  - Latch valueIn into the working register.
  - Clear rot counter (4 bits) to 0, clear found/invertOut/data12Out, set busy=1.
- SEARCH, each cycle: candidate = ROL(work, 2*rot).
  - Hit when candidate[31:8]==0. On a hit: data12Out={rot, candidate[7:0]}, found=1, go to DONE.
  - Otherwise, if rot==15, it is a miss (see Configuration). Else rot increments.
- The smallest rotation wins. The result is unique for the bench to check.
- valueIn==0 hits at rot 0, giving data12Out=0x000 and found=1.
- start while busy is ignored. valueIn changes while busy have no effect.
- DONE lasts exactly one cycle:
  - done=1 and busy=0.
  - Result outputs hold until the next accepted start.

## Timing
- Reset, asynchronous: state=IDLE, busy=0, done=0, found=0, data12Out=0, invertOut=0, rot=0, working register=0.
- Reset mid-search aborts immediately. No done pulse follows.
- Latency, with start sampled at edge E:
  - busy=1 after E.
  - A hit at rotation k gives done=1 in the cycle after edge E+k+1.
  - Best case is done at E+1. A direct miss gives done at E+16.
- busy falls on the same edge that done rises.
- Back-to-back operation: start asserted during the DONE cycle is accepted. Throughput is 1 result per k+2 cycles.

## Configuration
- Macro IMM_ENCODER_INVERT_EN.
- Defined: after a direct miss at rot 15, the working register is loaded with ~value, rot resets to 0, and a second 16-cycle pass runs.
  - A second-pass hit sets invertOut=1.
  - Worst-case miss: done at E+32, found=0.
- Undefined:
  - The single pass ends at rot 15.
  - invertOut is constant 0 and no inversion logic is present.

## Test plan
- valueIn=0x000000FF, start 1 cycle -> done 1 cycle after start edge, found=1, data12Out=0x0FF, invertOut=0.
- valueIn=0xFF000000 -> done at E+5, found=1, data12Out=0x4FF. Then valueIn=0x000003FC -> done at E+16, data12Out=0xFFF.
- valueIn=0x00000102 (unencodable) -> found=0, data12Out=0x000:
  - done at E+16 with the macro undefined.
  - done at E+32 with the macro defined.
- Macro defined, valueIn=0xFFFFFF00 -> done at E+17, found=1, invertOut=1, data12Out=0x0FF. Macro undefined -> done at E+16, found=0.
- Start 0x00000102, pulse start again with 0x000000FF at E+3:
  - The second start is ignored and the first result completes.
  - start held high in the DONE cycle begins a new search on the current valueIn.
- Reset asserted at E+5 of a 0x00000102 search -> all outputs 0 asynchronously, no done pulse. After release, start with 0x000000FF -> normal 1-cycle result.
